pipeline_subtractor_16bit: RTL and testbench
============================================

// Module: pipeline_subtractor_16bit
// PURPOSE
//  Pipelined WIDTH-bit subtractor (diff = a - b - bin) built from 4-bit slices, one slice per stage.
//  Counterpart of the pipelined adder: the same slice/skew datapath, with borrow propagation
//  instead of carry. Adds a valid/ready handshake with backpressure. Sits in the arithmetic
//  datapath wherever the adder's result must be undone or compared.
// PARAMETERS
//  WIDTH    16  operand width; must be a multiple of SLICE_W
//  SLICE_W  4   bits resolved per pipeline stage; NSTAGE = WIDTH/SLICE_W (4 by default)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset_n    in   1      asynchronous assert, active-low; all state cleared while low
//  in_valid   in   1      a/b/bin valid this cycle
//  in_ready   out  1      block accepts an operand set this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      diff/bout valid
//  out_ready  in   1      downstream accepts the result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out; 1 iff a < b + bin (unsigned)
//  ovf        out  1      signed overflow (only with PIPE_SUB_OVF_EN)
// BEHAVIOUR
//  - Reset: all pipeline registers, valid bits, diff, bout and ovf go to 0; in_ready=1 after reset.
//  - Per slice: s = a_k + ~b_k + ~borrow_in; borrow_out = ~carry_out. Slice 0 uses bin.
//  - Stage k (k=0..NSTAGE-1) resolves slice k using the borrow registered by stage k-1.
//    Upper operand slices are delay-skewed to match; lower result slices are delay-aligned,
//    so all WIDTH bits of one transaction appear together.
//  - Valid bit travels with the data; one valid flop per stage.
//  - Latency: NSTAGE cycles from accepted input (in_valid & in_ready) to out_valid. Throughput:
//    1 per cycle when out_ready=1.
//  - Stall: in_ready = ~out_valid | out_ready. When in_ready=0, every stage holds (global
//    enable). diff/bout/ovf stay stable while out_valid=1 and out_ready=0.
//  - Bubbles: in_valid=0 on an enabled cycle inserts a bubble; data regs may update but valid=0.
//  - Simultaneous accept and emit while full: both happen in the same cycle; no loss, no duplicate.
//  - Reset mid-operation: all in-flight transactions are dropped; out_valid=0 next cycle.
//  - Result: for each accepted set, exactly one output with diff = (a - b - bin) mod 2^WIDTH and
//    bout as above.
// CONFIGURATION
//  PIPE_SUB_OVF_EN defined: ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]). MSB operand bits are
//    carried to the last stage; ovf is registered and aligned with diff, and reset to 0.
//  Not defined: ovf is tied to 0 and no extra flops are added.
// STRUCTURE
//  Shared package pipe_arith_pkg: SLICE_W, NSTAGE calc, localparam check WIDTH % SLICE_W == 0.
//  Sub-module sub_slice_4bit: combinational 4-bit carry-select slice (two ripple paths for borrow
//    0/1, then a mux), so its selection delay is short. Top: generate loop of NSTAGE stages plus
//    skew/align shift registers, all using the common enable.
// TESTING
//  1 reset: hold reset_n=0 for 3 cycles -> out_valid=0, diff=0, bout=0, in_ready=1.
//  2 a=0x1234 b=0x0234 bin=0 -> 4 cycles later diff=0x1000 bout=0; a=0x0000 b=0x0001 -> 0xFFFF bout=1.
//  3 borrow chain: a=0x1000 b=0x0001 bin=1 -> diff=0x0FFE bout=0; a=0x0000 b=0x0000 bin=1 -> 0xFFFF bout=1.
//  4 stream 8 back-to-back sets, out_ready toggled 1,0,0,1 -> 8 results in order, none lost or
//    repeated, outputs stable during stall, in_ready=0 exactly while out_valid&~out_ready.
//  5 reset_n pulsed low with 3 transactions in flight -> out_valid=0, none of those 3 ever emitted.
//  6 PIPE_SUB_OVF_EN: a=0x8000 b=0x0001 -> diff=0x7FFF ovf=1; a=0x7FFF b=0xFFFF -> 0x8000 ovf=1;
//    a=0x0005 b=0x0003 -> ovf=0. Random 10k vectors vs reference model with both builds.

Source files
------------

// File: rtl/pipe_arith_pkg.sv
// Shared sizing helpers for the sliced pipelined add/subtract datapaths.
package pipe_arith_pkg;

    localparam int DEF_SLICE_W = 4;

    function automatic int calc_nstage(input int width, input int slice_w);
        return width / slice_w;
    endfunction

    function automatic bit width_ok(input int width, input int slice_w);
        return (slice_w > 0) && ((width % slice_w) == 0);
    endfunction

endpackage

// File: rtl/sub_slice_4bit.sv
// Combinational carry-select subtract slice: both borrow-in cases ripple in
// parallel, the registered borrow only drives the final mux.
module sub_slice_4bit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W-1:0] s0, s1;
    logic         c0, c1;

    // a + ~b + carry_in, where carry_in = ~borrow_in (path 0: borrow 0, path 1: borrow 1)
    always_comb begin
        c0 = 1'b1;
        c1 = 1'b0;
        s0 = '0;
        s1 = '0;
        for (int i = 0; i < W; i++) begin
            s0[i] = a[i] ^ ~b[i] ^ c0;
            s1[i] = a[i] ^ ~b[i] ^ c1;
            c0    = (a[i] & ~b[i]) | ((a[i] ^ ~b[i]) & c0);
            c1    = (a[i] & ~b[i]) | ((a[i] ^ ~b[i]) & c1);
        end
    end

    assign diff = bin ? s1 : s0;
    assign bout = bin ? ~c1 : ~c0;

endmodule

// File: rtl/pipeline_subtractor_16bit.sv
// Pipelined a - b - bin, one SLICE_W slice per stage, valid/ready with global stall.
// Optional signed-overflow output enabled by defining PIPE_SUB_OVF_EN.
module pipeline_subtractor_16bit
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSTAGE = calc_nstage(WIDTH, SLICE_W);

    if (!width_ok(WIDTH, SLICE_W)) begin : g_bad_width
        $error("WIDTH must be a multiple of SLICE_W");
    end

    logic                             en;
    logic [NSTAGE:0]                  vld_pipe;
    logic [NSTAGE:0]                  brw;
    logic [NSTAGE-1:0][SLICE_W-1:0]   a_sk, b_sk, sd;
    logic [NSTAGE-1:0]                sbo;

    // Every stage shares one enable: the whole pipe freezes while the output is held.
    assign en          = ~vld_pipe[NSTAGE] | out_ready;
    assign in_ready    = en;
    assign vld_pipe[0] = in_valid;
    assign brw[0]      = bin;
    assign out_valid   = vld_pipe[NSTAGE];
    assign bout        = brw[NSTAGE];

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        localparam int AL = NSTAGE - s;

        // Operand slice s waits s cycles so it meets the borrow from stage s-1.
        if (s > 0) begin : g_skew
            logic [s-1:0][SLICE_W-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q[0] <= a[s*SLICE_W +: SLICE_W];
                    b_q[0] <= b[s*SLICE_W +: SLICE_W];
                    for (int i = 1; i < s; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                    end
                end
            end
            assign a_sk[s] = a_q[s-1];
            assign b_sk[s] = b_q[s-1];
        end else begin : g_noskew
            assign a_sk[s] = a[SLICE_W-1:0];
            assign b_sk[s] = b[SLICE_W-1:0];
        end

        sub_slice_4bit #(.W(SLICE_W)) u_slice (
            .a    (a_sk[s]),
            .b    (b_sk[s]),
            .bin  (brw[s]),
            .diff (sd[s]),
            .bout (sbo[s])
        );

        // Stage register plus the alignment delay that lets all slices exit together.
        logic [AL-1:0][SLICE_W-1:0] r_q;
        logic                       br_q, v_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_q  <= '0;
                br_q <= 1'b0;
                v_q  <= 1'b0;
            end else if (en) begin
                r_q[0] <= sd[s];
                br_q   <= sbo[s];
                v_q    <= vld_pipe[s];
                for (int i = 1; i < AL; i++) r_q[i] <= r_q[i-1];
            end
        end
        assign brw[s+1]                    = br_q;
        assign vld_pipe[s+1]               = v_q;
        assign diff[s*SLICE_W +: SLICE_W]  = r_q[AL-1];
    end

`ifdef PIPE_SUB_OVF_EN
    // Operand MSBs arrive at the last stage through the skew lines already.
    logic a_msb, b_msb, d_msb, ovf_q;
    assign a_msb = a_sk[NSTAGE-1][SLICE_W-1];
    assign b_msb = b_sk[NSTAGE-1][SLICE_W-1];
    assign d_msb = sd[NSTAGE-1][SLICE_W-1];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  ovf_q <= 1'b0;
        else if (en)   ovf_q <= (a_msb ^ b_msb) & (d_msb ^ a_msb);
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_subtractor_16bit.sv
// Directed + scoreboard bench for pipeline_subtractor_16bit (both ovf builds).
module tb_pipeline_subtractor_16bit;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, bin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, bout, ovf;
    logic [15:0] diff;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PIPE_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    pipeline_subtractor_16bit #(.WIDTH(16), .SLICE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand set into an idle pipe and waits (bounded) for its result.
    task automatic send_one(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                            output logic [15:0] rd, output logic rbo, output logic rov,
                            output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ta; b = tb; bin = tbin;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = diff; rbo = bout; rov = ovf;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        n_tests++; if (diff !== 16'h0)     begin n_fail++; $display("FAIL reset diff got=%h exp=0000", diff); end
        n_tests++; if (bout !== 1'b0)      begin n_fail++; $display("FAIL reset bout got=%b exp=0", bout); end
        n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset ovf got=%b exp=0", ovf); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
        reset_n = 1'b1;
        tick();
    endtask

    // Directed vectors: basic, borrow chain, and signed-overflow corners.
    task automatic test_vectors();
        logic [15:0] va [7] = '{16'h1234, 16'h0000, 16'h1000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0005};
        logic [15:0] vb [7] = '{16'h0234, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF, 16'h0003};
        logic        vi [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] vd [7] = '{16'h1000, 16'hFFFF, 16'h0FFE, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0002};
        logic        vo [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] rd;
        logic        rbo, rov;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            send_one(va[i], vb[i], vi[i], rd, rbo, rov, lat);
            n_tests++; if (lat !== 4)     begin n_fail++; $display("FAIL vec%0d latency got=%0d exp=4", i, lat); end
            n_tests++; if (rd !== vd[i])  begin n_fail++; $display("FAIL vec%0d diff got=%h exp=%h", i, rd, vd[i]); end
            n_tests++; if (rbo !== vo[i]) begin n_fail++; $display("FAIL vec%0d bout got=%b exp=%b", i, rbo, vo[i]); end
            n_tests++; if (rov !== (OVF_ON & vv[i])) begin n_fail++; $display("FAIL vec%0d ovf got=%b exp=%b", i, rov, OVF_ON & vv[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8] = '{16'h0010, 16'hFFFF, 16'h0001, 16'hABCD, 16'h00F0, 16'h0F00, 16'h8000, 16'h1234};
        logic [15:0] vb [8] = '{16'h0001, 16'h0001, 16'h0002, 16'h1234, 16'h000F, 16'h00F0, 16'h8000, 16'h1234};
        logic        vi [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] vd [8] = '{16'h000F, 16'hFFFE, 16'hFFFF, 16'h9998, 16'h00E1, 16'h0E0F, 16'hFFFF, 16'h0000};
        logic        vo [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          sent = 0, recv = 0, cyc = 0, extra = 0;
        logic        held = 1'b0, held_bo = 1'b0, acc;
        logic [15:0] held_d = '0;
        while (recv < 8 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            if (sent < 8) begin a = va[sent]; b = vb[sent]; bin = vi[sent]; end
            #1;
            if (held) begin
                n_tests++;
                if (out_valid !== 1'b1 || diff !== held_d || bout !== held_bo) begin
                    n_fail++; $display("FAIL stall_hold v=%b diff=%h bout=%b exp v=1 diff=%h bout=%b", out_valid, diff, bout, held_d, held_bo);
                end
            end
            n_tests++;
            if (in_ready !== ~(out_valid & ~out_ready)) begin
                n_fail++; $display("FAIL b2b in_ready got=%b exp=%b", in_ready, ~(out_valid & ~out_ready));
            end
            held = out_valid & ~out_ready; held_d = diff; held_bo = bout;
            if (out_valid && out_ready) begin
                n_tests++;
                if (diff !== vd[recv] || bout !== vo[recv]) begin
                    n_fail++; $display("FAIL b2b[%0d] diff=%h bout=%b exp diff=%h bout=%b", recv, diff, bout, vd[recv], vo[recv]);
                end
                recv++;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        n_tests++; if (recv != 8 || sent != 8) begin n_fail++; $display("FAIL b2b_count recv=%0d sent=%0d exp 8/8", recv, sent); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            tick();
            if (out_valid) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL b2b_duplicate got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_in_flight();
        logic [15:0] va [3] = '{16'h5555, 16'h6666, 16'h7777};
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = va[i]; b = 16'h1111; bin = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_reset out_valid got=%b exp=0", out_valid); end
        tick();
        reset_n = 1'b1;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flight_dropped emitted=%0d exp=0", seen); end
    endtask

    task automatic test_random();
        logic [15:0] qd[$];
        logic        qb[$], qo[$];
        int          sent = 0, recv = 0, cyc = 0, sa, sb, sr;
        logic [16:0] full;
        logic        acc;
        while (recv < 400 && cyc < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (qd.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious diff=%h exp no output", diff);
                end else begin
                    if (diff !== qd[0] || bout !== qb[0] || ovf !== qo[0]) begin
                        n_fail++; $display("FAIL rand[%0d] diff=%h bout=%b ovf=%b exp %h %b %b", recv, diff, bout, ovf, qd[0], qb[0], qo[0]);
                    end
                    void'(qd.pop_front()); void'(qb.pop_front()); void'(qo.pop_front());
                end
                recv++;
            end
            acc = in_valid & in_ready;
            if (acc) begin
                full = {1'b0, a} - {1'b0, b} - {16'h0, bin};
                sa = $signed(a); sb = $signed(b);
                sr = sa - sb - int'(bin);
                qd.push_back(full[15:0]);
                qb.push_back(full[16]);
                qo.push_back(OVF_ON & ((sr > 32767) || (sr < -32768)));
                sent++;
            end
            tick();
            cyc++;
        end
        n_tests++; if (recv != 400) begin n_fail++; $display("FAIL rand_count recv=%0d exp=400", recv); end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
